// File: rtl/psum_pack_writer.sv
// -----------------------------------------------------------------------------
// psum_pack_writer
//
// Sits downstream of the sfp stage. It accepts one psum_bw-bit result per
// valid/ready handshake and packs col of them into a single col*psum_bw-bit
// word. Each full word is written to the psum SRAM, starting at a base address
// and using consecutive addresses. A start command sets the base address and
// the number of words in the job. done pulses for one cycle when the job ends.
//
// Optional feature macro: PSUM_PACK_FLUSH_EN
//   When defined, the module adds a flush input. A flush during collection
//   writes a partially filled word. The unfilled upper lanes are written as
//   zero.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   start      in   job start, honoured only while idle
//   base_addr  in   first SRAM address of the job
//   num_words  in   number of words in the job (0 = empty job)
//   in         in   one sfp result lane
//   in_valid   in   lane on `in` is valid
//   flush      in   (PSUM_PACK_FLUSH_EN only) write the partial word now
//   in_ready   out  block accepts a lane this cycle
//   sram_cen   out  SRAM chip enable, active-low
//   sram_wen   out  SRAM write enable, active-low
//   sram_addr  out  SRAM address
//   sram_d     out  SRAM write data
//   busy       out  a job is collecting or writing
//   done       out  one-cycle job completion pulse
// -----------------------------------------------------------------------------
module psum_pack_writer #(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int addr_bw = 4,
    parameter int cnt_bw  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_bw-1:0]     base_addr,
    input  logic [cnt_bw-1:0]      num_words,
    input  logic [psum_bw-1:0]     in,
    input  logic                   in_valid,
`ifdef PSUM_PACK_FLUSH_EN
    input  logic                   flush,
`endif
    output logic                   in_ready,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [addr_bw-1:0]     sram_addr,
    output logic [col*psum_bw-1:0] sram_d,
    output logic                   busy,
    output logic                   done
);

    localparam int LANE_W = (col > 1) ? $clog2(col) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                   state;
    logic [LANE_W-1:0]        lane_cnt;
    logic [cnt_bw-1:0]        word_cnt;
    logic [cnt_bw-1:0]        num_q;
    logic [addr_bw-1:0]       cur_addr;
    logic [col*psum_bw-1:0]   pack;

    logic                     accept;
    logic                     last_lane;
    logic                     do_flush;
    logic                     word_last;
    logic [col*psum_bw-1:0]   pack_next;

    // NOTE: every signal gets a default at the top of always_comb, so no path
    // leaves it unassigned. This keeps the block free of inferred latches.
    always_comb begin
        accept    = in_valid && in_ready;
        last_lane = accept && (lane_cnt == LANE_W'(col - 1));
        pack_next = pack;
        for (int i = 0; i < col; i++) begin
            if (accept && (lane_cnt == LANE_W'(i)))
                pack_next[i*psum_bw +: psum_bw] = in;
        end
`ifdef PSUM_PACK_FLUSH_EN
        // Flush is judged on the lanes already held. A lane accepted in the
        // same cycle is merged into the word through pack_next.
        do_flush = flush && (lane_cnt != '0);
`else
        do_flush = 1'b0;
`endif
        // The compare is one bit wider, so word_cnt+1 cannot wrap.
        word_last = ({1'b0, word_cnt} + 1'b1) >= {1'b0, num_q};
    end

    // NOTE: all state and output registers use non-blocking assignments. Every
    // register then samples the values from before the edge, in any order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            lane_cnt  <= '0;
            word_cnt  <= '0;
            num_q     <= '0;
            cur_addr  <= '0;
            pack      <= '0;
            in_ready  <= 1'b0;
            sram_cen  <= 1'b1;
            sram_wen  <= 1'b1;
            sram_addr <= '0;
            sram_d    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr <= base_addr;
                        num_q    <= num_words;
                        word_cnt <= '0;
                        lane_cnt <= '0;
                        pack     <= '0;
                        if (num_words != '0) begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        pack     <= pack_next;
                        lane_cnt <= lane_cnt + LANE_W'(1);
                    end
                    if (last_lane || do_flush) begin
                        // The write data comes from pack_next. A lane accepted
                        // at this edge is therefore included in the word.
                        state     <= WRITE;
                        in_ready  <= 1'b0;
                        sram_cen  <= 1'b0;
                        sram_wen  <= 1'b0;
                        sram_addr <= cur_addr;
                        sram_d    <= pack_next;
                    end
                end

                WRITE: begin
                    sram_cen <= 1'b1;
                    sram_wen <= 1'b1;
                    cur_addr <= cur_addr + addr_bw'(1);
                    word_cnt <= word_cnt + cnt_bw'(1);
                    // Clearing pack makes the lanes of a flushed word that
                    // were never filled read as zero.
                    lane_cnt <= '0;
                    pack     <= '0;
                    if (word_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
